// File: rtl/mmio_gpio_bank.sv
// mmio_gpio_bank
//   Memory-mapped bank of NPORTS 8-bit output ports and NPORTS 8-bit input
//   ports for the mcu data-memory bus. Outputs have direct, atomic-set and
//   atomic-clear aliases. Inputs are synchronised, compared against their
//   previous value to raise sticky change flags (write-1-to-clear), and the
//   flags are masked into a single level interrupt.
//
//   Byte offsets from BASE (p = port index):
//     0x00+p OUT   0x08+p SET   0x10+p CLR
//     0x18+p IN    0x20+p CHG   0x28+p MASK
//   Unused offsets inside the block read 0 with rd_hit=1.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   addr      byte address from the CPU
//   wen       write strobe, one cycle per write
//   byt       1 = byte access, 0 = 16-bit word access
//   wdata     write data
//   rdata     read data for the address presented on the previous cycle
//   rd_hit    rdata belongs to this block (aligned with rdata)
//   port_out  output port bits, port p = [8p+7:8p]
//   port_in   asynchronous input pins, port p = [8p+7:8p]
//   irq       level interrupt, |(CHG & MASK) delayed by one cycle
module mmio_gpio_bank #(
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned BASE       = 32'h0000_0080,
    parameter int          NPORTS     = 2,
    parameter logic [NPORTS*8-1:0] OUT_RESET = {(NPORTS*8){1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wen,
    input  logic                  byt,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic                  rd_hit,
    output logic [NPORTS*8-1:0]   port_out,
    input  logic [NPORTS*8-1:0]   port_in,
    output logic                  irq
);

    localparam int W = NPORTS * 8;
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE);

    // True when a byte address falls inside this 64-byte block.
    function automatic logic in_block(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:6] == BASE_A[ADDR_WIDTH-1:6];
    endfunction

    // Read value of one byte offset; unused offsets return 0.
    function automatic logic [7:0] rd_byte(
        input logic [5:0]   off,
        input logic [W-1:0] o,
        input logic [W-1:0] i,
        input logic [W-1:0] c,
        input logic [W-1:0] m
    );
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NPORTS; k++) begin
            if (off[2:0] == 3'(k)) begin
                case (off[5:3])
                    3'd0, 3'd1, 3'd2: b = o[k*8 +: 8];
                    3'd3:             b = i[k*8 +: 8];
                    3'd4:             b = c[k*8 +: 8];
                    3'd5:             b = m[k*8 +: 8];
                    default:          b = 8'h00;
                endcase
            end else begin
            end
        end
        return b;
    endfunction

    logic [W-1:0] out_r;
    logic [W-1:0] mask_r;
    logic [W-1:0] chg_r;
    logic [W-1:0] sync1_r;
    logic [W-1:0] sync2_r;
    logic [W-1:0] prev_r;
    logic [1:0]   warm_r;
    logic         irq_r;
    logic [5:0]   addr_d_r;
    logic         rd_hit_r;

    logic [W-1:0] out_n_s;
    logic [W-1:0] mask_n_s;
    logic [W-1:0] w1c_s;
    logic [W-1:0] event_s;
    logic         lane_en_s  [2];
    logic [5:0]   lane_off_s [2];
    logic [7:0]   lane_dat_s [2];

    // Split a bus write into up to two byte lanes. Lane 1 only exists for
    // a word write at an even address; it is always addr|1, so it lies in
    // the same block as lane 0.
    always_comb begin
        lane_en_s[0]  = wen && in_block(addr);
        lane_off_s[0] = addr[5:0];
        lane_dat_s[0] = addr[0] ? wdata[15:8] : wdata[7:0];
        lane_en_s[1]  = wen && !byt && !addr[0] && in_block(addr);
        lane_off_s[1] = {addr[5:1], 1'b1};
        lane_dat_s[1] = wdata[15:8];
    end

    // Apply lane writes to OUT/SET/CLR/MASK and collect CHG clear bits.
    always_comb begin
        out_n_s  = out_r;
        mask_n_s = mask_r;
        w1c_s    = {W{1'b0}};
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < NPORTS; k++) begin
                if (lane_en_s[l] && (lane_off_s[l][2:0] == 3'(k))) begin
                    case (lane_off_s[l][5:3])
                        3'd0: out_n_s[k*8 +: 8]  = lane_dat_s[l];
                        3'd1: out_n_s[k*8 +: 8]  = out_n_s[k*8 +: 8] | lane_dat_s[l];
                        3'd2: out_n_s[k*8 +: 8]  = out_n_s[k*8 +: 8] & ~lane_dat_s[l];
                        3'd4: w1c_s[k*8 +: 8]    = w1c_s[k*8 +: 8] | lane_dat_s[l];
                        3'd5: mask_n_s[k*8 +: 8] = lane_dat_s[l];
                        default: ;
                    endcase
                end else begin
                end
            end
        end
    end

    // Change events are held off until the warm-up counter has drained so
    // the synchroniser filling after reset does not raise flags.
    always_comb begin
        if (warm_r == 2'd0) begin
            event_s = sync2_r ^ prev_r;
        end else begin
            event_s = {W{1'b0}};
        end
    end

    // State registers: ports, flags, synchroniser chain, warm-up, read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r    <= OUT_RESET;
            mask_r   <= {W{1'b0}};
            chg_r    <= {W{1'b0}};
            sync1_r  <= {W{1'b0}};
            sync2_r  <= {W{1'b0}};
            prev_r   <= {W{1'b0}};
            warm_r   <= 2'd3;
            irq_r    <= 1'b0;
            addr_d_r <= 6'd0;
            rd_hit_r <= 1'b0;
        end else begin
            out_r    <= out_n_s;
            mask_r   <= mask_n_s;
            // A new event on a bit beats a simultaneous clear of that bit.
            chg_r    <= (chg_r & ~w1c_s) | event_s;
            sync1_r  <= port_in;
            sync2_r  <= sync1_r;
            prev_r   <= sync2_r;
            if (warm_r != 2'd0) begin
                warm_r <= warm_r - 2'd1;
            end else begin
                warm_r <= warm_r;
            end
            irq_r    <= |(chg_r & mask_r);
            addr_d_r <= addr[5:0];
            rd_hit_r <= in_block(addr);
        end
    end

    // Read mux on the registered address; the word is always the aligned pair.
    always_comb begin
        if (rd_hit_r) begin
            rdata = {rd_byte(addr_d_r | 6'h01, out_r, sync2_r, chg_r, mask_r),
                     rd_byte(addr_d_r & 6'h3E, out_r, sync2_r, chg_r, mask_r)};
        end else begin
            rdata = 16'h0000;
        end
    end

    assign rd_hit   = rd_hit_r;
    assign port_out = out_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Self-checking bench for mmio_gpio_bank (default parameters, NPORTS=2).
// Directed table and hand-written sequences, then random traffic checked
// against a behavioural model of the register map.
module tb_mmio_gpio_bank;

    localparam int NP   = 2;
    localparam int BASE = 'h080;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic        wen;
    logic        byt;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rd_hit;
    logic [15:0] port_out;
    logic [15:0] port_in;
    logic        irq;

    int total = 0;
    int bad   = 0;

    mmio_gpio_bank dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wen      (wen),
        .byt      (byt),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_hit   (rd_hit),
        .port_out (port_out),
        .port_in  (port_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pin history: h1 = pins seen at the last edge, h2 = one edge earlier
    // (the visible IN value), h3 = two edges earlier (the previous IN).
    logic [15:0] m_out, m_mask, m_chg, m_w1c;
    logic [15:0] h1, h2, h3;
    logic        m_irq;
    int          m_cnt;
    int          m_addrd;

    function automatic logic [7:0] m_byte(input int off);
        int g, p;
        g = off / 8;
        p = off % 8;
        if (p >= NP || g >= 6) return 8'h00;
        case (g)
            0, 1, 2: return m_out[p*8 +: 8];
            3:       return h2[p*8 +: 8];
            4:       return m_chg[p*8 +: 8];
            default: return m_mask[p*8 +: 8];
        endcase
    endfunction

    task automatic m_wr(input int a, input logic [7:0] d);
        int off, g, p;
        off = a - BASE;
        if (off < 0 || off > 63) return;
        g = off / 8;
        p = off % 8;
        if (p >= NP) return;
        case (g)
            0: m_out[p*8 +: 8]  = d;
            1: m_out[p*8 +: 8]  = m_out[p*8 +: 8] | d;
            2: m_out[p*8 +: 8]  = m_out[p*8 +: 8] & ~d;
            4: m_w1c[p*8 +: 8]  = m_w1c[p*8 +: 8] | d;
            5: m_mask[p*8 +: 8] = d;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        logic [15:0] ev;
        logic        irq_n;
        if (rst) begin
            m_out = 16'h0000; m_mask = 16'h0000; m_chg = 16'h0000;
            h1 = 16'h0000; h2 = 16'h0000; h3 = 16'h0000;
            m_irq = 1'b0; m_cnt = 0; m_addrd = 0;
        end else begin
            ev    = (m_cnt >= 3) ? (h2 ^ h3) : 16'h0000;
            irq_n = |(m_chg & m_mask);
            m_w1c = 16'h0000;
            if (wen) begin
                if (byt) m_wr(int'(addr), addr[0] ? wdata[15:8] : wdata[7:0]);
                else if (!addr[0]) begin
                    m_wr(int'(addr), wdata[7:0]);
                    m_wr(int'(addr) + 1, wdata[15:8]);
                end else m_wr(int'(addr), wdata[15:8]);
            end
            m_chg = (m_chg & ~m_w1c) | ev;
            m_irq = irq_n;
            h3 = h2; h2 = h1; h1 = port_in;
            if (m_cnt < 3) m_cnt++;
            m_addrd = int'(addr);
        end
    end

    function automatic logic m_hit();
        return (m_addrd >= BASE) && (m_addrd < BASE + 64);
    endfunction

    function automatic logic [15:0] m_rdata();
        int off;
        if (!m_hit()) return 16'h0000;
        off = m_addrd - BASE;
        return {m_byte(off | 1), m_byte(off & 62)};
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        wen;
        logic        byt;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] e_out;
        logic [15:0] e_rd;
        logic        e_hit;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 10'h080, 16'hA55A, 16'hA55A, 16'hA55A, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 10'h080, 16'h0000, 16'hA55A, 16'hA55A, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 10'h081, 16'h3C00, 16'h3C5A, 16'h3C5A, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 10'h088, 16'h00F0, 16'h3CFA, 16'h3CFA, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 10'h090, 16'h0030, 16'h3CCA, 16'h3CCA, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 10'h082, 16'h0000, 16'h3CCA, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 10'h0C0, 16'h0000, 16'h3CCA, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 10'h0C0, 16'hFFFF, 16'h3CCA, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 10'h0B0, 16'hFFFF, 16'h3CCA, 16'h0000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 10'h081, 16'h1200, 16'h12CA, 16'h12CA, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 10'h0A8, 16'h0303, 16'h12CA, 16'h0303, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 10'h0A8, 16'h0000, 16'h12CA, 16'h0000, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 10'h098, 16'h0000, 16'h12CA, 16'h0000, 1'b1};

        rst = 1'b1; wen = 1'b0; byt = 1'b0; addr = 10'h000; wdata = 16'h0000;
        port_in = 16'h0000;
        tick(); tick();
        chk("rst_out", port_out, 16'h0000);
        chk("rst_irq", {15'h0000, irq}, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_hit", {15'h0000, rd_hit}, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            wen = vecs[i].wen; byt = vecs[i].byt;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            tick();
            chk($sformatf("vec%0d_out", i), port_out, vecs[i].e_out);
            chk($sformatf("vec%0d_rd", i), rdata, vecs[i].e_rd);
            chk($sformatf("vec%0d_hit", i), {15'h0000, rd_hit}, {15'h0000, vecs[i].e_hit});
            chk($sformatf("vec%0d_irq", i), {15'h0000, irq}, 16'h0000);
        end
        wen = 1'b0;

        // Input held high through reset: no flag after warm-up.
        port_in = 16'h0001; rst = 1'b1;
        tick(); tick();
        rst = 1'b0; addr = 10'h0A0; byt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("warm_chg%0d", i), rdata, 16'h0000);
            chk($sformatf("warm_irq%0d", i), {15'h0000, irq}, 16'h0000);
        end
        wen = 1'b1; addr = 10'h0A8; wdata = 16'h0001;
        tick();
        wen = 1'b0; addr = 10'h098;
        port_in = 16'h0000;
        tick();
        chk("in_e1", rdata, 16'h0001);
        tick();
        chk("in_e2", rdata, 16'h0000);
        addr = 10'h0A0;
        tick();
        chk("chg_set", rdata, 16'h0001);
        chk("irq_e3", {15'h0000, irq}, 16'h0000);
        tick();
        chk("irq_e4", {15'h0000, irq}, 16'h0001);

        // W1C in the same cycle a new edge reaches prev: set wins.
        port_in = 16'h0001;
        tick(); tick();
        wen = 1'b1; byt = 1'b1; addr = 10'h0A0; wdata = 16'h0001;
        tick();
        chk("race_chg", rdata, 16'h0001);
        chk("race_irq", {15'h0000, irq}, 16'h0001);
        tick();
        chk("w1c_chg", rdata, 16'h0000);
        chk("w1c_irq_lag", {15'h0000, irq}, 16'h0001);
        wen = 1'b0; byt = 1'b0;
        tick();
        chk("w1c_irq", {15'h0000, irq}, 16'h0000);

        // Reset overrides a concurrent write; high inputs raise no flags.
        port_in = 16'hFFFF; rst = 1'b1;
        wen = 1'b1; byt = 1'b0; addr = 10'h080; wdata = 16'hFFFF;
        tick();
        chk("mid_rst_out", port_out, 16'h0000);
        chk("mid_rst_irq", {15'h0000, irq}, 16'h0000);
        chk("mid_rst_hit", {15'h0000, rd_hit}, 16'h0000);
        rst = 1'b0; wen = 1'b0; addr = 10'h0A0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mid_warm_chg%0d", i), rdata, 16'h0000);
        end
        chk("mid_warm_out", port_out, 16'h0000);
        chk("mid_warm_irq", {15'h0000, irq}, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(79) == 0);
            wen   = $urandom_range(1);
            byt   = $urandom_range(1);
            wdata = 16'($urandom);
            if ($urandom_range(7) != 0) addr = 10'(BASE + $urandom_range(63));
            else addr = 10'($urandom);
            if ($urandom_range(3) == 0) port_in = port_in ^ 16'($urandom);
            tick();
            chk($sformatf("rnd%0d_out", i), port_out, m_out);
            chk($sformatf("rnd%0d_rd", i), rdata, m_rdata());
            chk($sformatf("rnd%0d_hit", i), {15'h0000, rd_hit}, {15'h0000, m_hit()});
            chk($sformatf("rnd%0d_irq", i), {15'h0000, irq}, {15'h0000, m_irq});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
